lap_stopwatch: RTL

Parametrised successor to the single-button stopwatch: a DIGITS-wide BCD hundredths-of-second counter with start/stop/clear control and a lap (split) freeze, driving a multiplexed common-anode 7-segment display. It sits between the board's push-buttons and the segment/digit-enable pins. Both buttons are debounced internally. A `sim` parameter shrinks all dividers so that benches run in short simulations.

---
 rtl/stopwatch_pkg.sv | 44 ++++
 rtl/btn_debounce.sv | 49 ++++
 rtl/lap_stopwatch.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the lap stopwatch: FSM encoding, segment codes
// and the reduced divider values used when the sim parameter is set.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam int unsigned SIM_TICK_DIV     = 10;
  localparam int unsigned SIM_DEBOUNCE_CYC = 16;
  localparam int unsigned SIM_SCAN_DIV     = 4;

  // Active-low segment codes, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: one-flop input register, level accepted after
// DEBOUNCE_CYC consecutive differing cycles, 1-cycle pulse on rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          r_sync;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_done;

  assign w_done = (r_cnt == CW'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= raw;
      r_press <= 1'b0;
      if (r_sync != r_level) begin
        if (w_done) begin
          r_level <= r_sync;
          r_press <= r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/lap_stopwatch.sv
// BCD hundredths stopwatch with start/stop/clear, lap freeze and a
// multiplexed common-anode 7-segment display driver.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned TICK_DIV     = 1_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned SCAN_DIV     = 100_000,
  parameter bit          sim          = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ButtonIn,
  input  logic              LapIn,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              f,
  output logic              g,
  output logic              dp,
  output logic [DIGITS-1:0] pos
);

  localparam int unsigned TD   = sim ? SIM_TICK_DIV     : TICK_DIV;
  localparam int unsigned DB   = sim ? SIM_DEBOUNCE_CYC : DEBOUNCE_CYC;
  localparam int unsigned SD   = sim ? SIM_SCAN_DIV     : SCAN_DIV;
  localparam int unsigned PW   = (TD > 1) ? $clog2(TD) : 1;
  localparam int unsigned SW   = (SD > 1) ? $clog2(SD) : 1;
  localparam int unsigned DW   = $clog2(DIGITS);
  localparam int unsigned CNTW = 4 * DIGITS;

  logic w_btn_level, w_btn_press;
  logic w_lap_level, w_lap_press;
  logic w_unused;

  btn_debounce #(.DEBOUNCE_CYC(DB)) u_btn (
    .clk   (clk),
    .reset (reset),
    .raw   (ButtonIn),
    .level (w_btn_level),
    .press (w_btn_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DB)) u_lap (
    .clk   (clk),
    .reset (reset),
    .raw   (LapIn),
    .level (w_lap_level),
    .press (w_lap_press)
  );

  assign w_unused = w_btn_level ^ w_lap_level;

  logic [1:0]      r_state;
  logic [PW-1:0]   r_presc;
  logic [CNTW-1:0] r_count;
  logic [CNTW-1:0] r_lap;
  logic            r_frozen;
  logic            w_tick;
  logic [CNTW-1:0] w_count_inc;

  assign w_tick = (r_state == ST_RUN) && (r_presc == PW'(TD - 1));

  always_comb begin
    logic w_carry;
    w_count_inc = r_count;
    w_carry     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_count_inc[4*i +: 4] = 4'd0;
        end else begin
          w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  // Tick is applied before the button case so a tick on the RUN->STOP edge
  // still counts, while STOP->IDLE clearing wins (no tick outside RUN anyway).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_presc  <= '0;
      r_count  <= '0;
      r_lap    <= '0;
      r_frozen <= 1'b0;
    end else begin
      if (w_tick) r_count <= w_count_inc;
      if (r_state == ST_RUN) r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_btn_press) begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_RUN;
            r_presc <= '0;
          end
          ST_RUN: begin
            r_state  <= ST_STOP;
            r_frozen <= 1'b0;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_frozen <= 1'b0;
          end
        endcase
      end else if (w_lap_press && (r_state == ST_RUN)) begin
        if (!r_frozen) begin
          r_lap    <= r_count;
          r_frozen <= 1'b1;
        end else begin
          r_frozen <= 1'b0;
        end
      end
    end
  end

  logic [SW-1:0]   r_scan;
  logic [DW-1:0]   r_digit;
  logic            w_step;
  logic [CNTW-1:0] w_disp;
  logic [3:0]      w_bcd;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic [DIGITS-1:0] r_pos;

  assign w_step = (r_scan == SW'(SD - 1));
  assign w_disp = r_frozen ? r_lap : r_count;
  assign w_bcd  = w_disp[{r_digit, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan  <= '0;
      r_digit <= '0;
      r_seg   <= SEG_0;
      r_dp    <= 1'b1;
      r_pos   <= ~DIGITS'(1);
    end else begin
      r_scan <= w_step ? '0 : r_scan + 1'b1;
      if (w_step) r_digit <= (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
      r_seg <= seg_decode(w_bcd);
      r_dp  <= (32'(r_digit) != 32'd2);
      r_pos <= ~(DIGITS'(1) << r_digit);
    end
  end

  assign {a, b, c, d, e, f, g} = r_seg;
  assign dp  = r_dp;
  assign pos = r_pos;

endmodule
